pipo: RTL and testbench

//  4-bit parallel-in parallel-out (PIPO) register.
//  - Four independent data bits are captured together on each rising clock edge.
//  - All four bits are presented in parallel on the outputs.
//  - Used as a generic pipeline/holding register between combinational stages.
//  - No shift, enable or serial path.

---
 rtl/pipo_pkg.sv | 14 +
 rtl/pipo_if.sv | 16 +
 rtl/pipo_dff.sv | 23 ++
 rtl/pipo.sv | 60 ++++++
 tb/tb_pipo.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/pipo_pkg.sv
// Shared bit mapping and reset default for the parallel/serial register family.
package pipo_pkg;

    localparam int unsigned WIDTH = 4;

    // Bit positions inside the packed {a,b,c,d} word: a is the MSB.
    localparam int unsigned BIT_A = 3;
    localparam int unsigned BIT_B = 2;
    localparam int unsigned BIT_C = 1;
    localparam int unsigned BIT_D = 0;

    localparam logic [WIDTH-1:0] RESET_VAL_DEFAULT = 4'b0000;

endpackage

// File: rtl/pipo_if.sv
// Parallel data bundle for the 4-bit PIPO register: p* in, q* out.
interface pipo_if;

    logic pa;
    logic pb;
    logic pc;
    logic pd;
    logic qa;
    logic qb;
    logic qc;
    logic qd;

    modport master (output pa, pb, pc, pd, input qa, qb, qc, qd);
    modport slave  (input pa, pb, pc, pd, output qa, qb, qc, qd);

endinterface

// File: rtl/pipo_dff.sv
// Single-bit D flip-flop with asynchronous active-low reset to a per-instance value.
module pipo_dff #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RESET_BIT;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipo.sv
// 4-bit parallel-in parallel-out register; each bit is an independent flop.
module pipo
    import pipo_pkg::*;
#(
    parameter logic [WIDTH-1:0] RESET_VAL = RESET_VAL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pa,
    input  logic pb,
    input  logic pc,
    input  logic pd,
    output logic qa,
    output logic qb,
    output logic qc,
    output logic qd
);

    pipo_if w_bus ();

    assign w_bus.pa = pa;
    assign w_bus.pb = pb;
    assign w_bus.pc = pc;
    assign w_bus.pd = pd;

    // Each bit resets to its own slice of RESET_VAL via the shared bit mapping.
    pipo_dff #(.RESET_BIT(RESET_VAL[BIT_A])) u_dff_a (
        .clk (clk),
        .rst (rst),
        .i_d (w_bus.pa),
        .o_q (w_bus.qa)
    );

    pipo_dff #(.RESET_BIT(RESET_VAL[BIT_B])) u_dff_b (
        .clk (clk),
        .rst (rst),
        .i_d (w_bus.pb),
        .o_q (w_bus.qb)
    );

    pipo_dff #(.RESET_BIT(RESET_VAL[BIT_C])) u_dff_c (
        .clk (clk),
        .rst (rst),
        .i_d (w_bus.pc),
        .o_q (w_bus.qc)
    );

    pipo_dff #(.RESET_BIT(RESET_VAL[BIT_D])) u_dff_d (
        .clk (clk),
        .rst (rst),
        .i_d (w_bus.pd),
        .o_q (w_bus.qd)
    );

    assign qa = w_bus.qa;
    assign qb = w_bus.qb;
    assign qc = w_bus.qc;
    assign qd = w_bus.qd;

endmodule

// File: tb/tb_pipo.sv
// Directed bench for pipo: default-reset instance plus a RESET_VAL=1010 instance.
module tb_pipo;

    logic clk;
    logic rst;
    logic rst2;
    logic qa2, qb2, qc2, qd2;

    int n_cmp;
    int n_bad;

    pipo_if u_if ();

    pipo u_dut (
        .clk (clk),
        .rst (rst),
        .pa  (u_if.pa),
        .pb  (u_if.pb),
        .pc  (u_if.pc),
        .pd  (u_if.pd),
        .qa  (u_if.qa),
        .qb  (u_if.qb),
        .qc  (u_if.qc),
        .qd  (u_if.qd)
    );

    pipo #(.RESET_VAL(4'b1010)) u_dut_rv (
        .clk (clk),
        .rst (rst2),
        .pa  (u_if.pa),
        .pb  (u_if.pb),
        .pc  (u_if.pc),
        .pd  (u_if.pd),
        .qa  (qa2),
        .qb  (qb2),
        .qc  (qc2),
        .qd  (qd2)
    );

    logic [3:0] q;
    logic [3:0] q2;
    assign q  = {u_if.qa, u_if.qb, u_if.qc, u_if.qd};
    assign q2 = {qa2, qb2, qc2, qd2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_p(input logic [3:0] v);
        {u_if.pa, u_if.pb, u_if.pc, u_if.pd} = v;
    endtask

    logic [3:0] vec [10];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vec = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
                4'b0110, 4'b0111, 4'b1001, 4'b1011, 4'b1111};

        // 1: reset held across two edges with all-ones input
        rst  = 1'b0;
        rst2 = 1'b1;
        drive_p(4'b1111);
        #1;
        check("reset_async", q, 4'b0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", q, 4'b0000);
        end

        // 2: release, walk the vector list with one-edge latency
        @(negedge clk);
        rst = 1'b1;
        drive_p(vec[0]);
        #1;
        check("release_no_edge", q, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("capture_%0d", i), q, vec[i]);
            @(negedge clk);
            if (i < 9) drive_p(vec[i + 1]);
        end

        // 3: only the value present at the edge is captured
        drive_p(4'b1010);
        #2;
        drive_p(4'b0101);
        #1;
        check("between_edges_hold", q, 4'b1111);
        @(posedge clk);
        #1;
        check("edge_value", q, 4'b0101);

        // 4: async reset midway between edges, then release with 0110
        @(negedge clk);
        drive_p(4'b1111);
        @(posedge clk);
        #1;
        check("preload_ones", q, 4'b1111);
        #2;
        rst = 1'b0;
        #1;
        check("mid_cycle_reset", q, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_discard", q, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        drive_p(4'b0110);
        @(posedge clk);
        #1;
        check("post_release", q, 4'b0110);

        // 5: constant input for five cycles, checked at both edges
        @(negedge clk);
        drive_p(4'b1001);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("const_pos", q, 4'b1001);
            @(negedge clk);
            check("const_neg", q, 4'b1001);
        end

        // Reset coincident with a rising edge must win over capture
        drive_p(4'b1110);
        @(posedge clk);
        rst = 1'b0;
        #1;
        check("reset_on_edge", q, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        // 6: non-default reset value
        rst2 = 1'b0;
        #1;
        check("rv_reset", q2, 4'b1010);
        @(posedge clk);
        #1;
        check("rv_reset_hold", q2, 4'b1010);
        @(negedge clk);
        rst2 = 1'b1;
        drive_p(4'b0011);
        @(posedge clk);
        #1;
        check("rv_capture", q2, 4'b0011);
        check("dflt_capture", q, 4'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
